sobel_gradient: RTL and testbench
=================================

Name: sobel_gradient

Overview:
Streaming 3x3 Sobel operator. It takes a raster-order 8-bit grayscale pixel stream and produces the 16-bit gradient magnitude stream consumed by the edge thresholding stage.
It sits between the camera/grayscale conversion path and the edge detector. It uses two internal line buffers to form the 3x3 window.
It produces exactly one gradient word per accepted pixel, at fixed latency.

Parameters:
IMG_WIDTH, 320, pixels per row (line buffer depth); minimum 3
IMG_HEIGHT, 240, rows per frame; minimum 3
COL_W, 9, column counter width; must satisfy 2^COL_W >= IMG_WIDTH
ROW_W, 8, row counter width; must satisfy 2^ROW_W >= IMG_HEIGHT

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
pix_in  input  8  grayscale pixel, raster order
pix_valid  input  1  pix_in accepted on this edge when high; no backpressure
sof  input  1  start of frame; qualified by pix_valid, marks pixel (0,0)
gradient  output  16  |Gx|+|Gy|, zero-extended from 11 bits
grad_valid  output  1  gradient valid this cycle (one-cycle pulse per accepted pixel)
grad_sof  output  1  high with the grad_valid corresponding to the sof pixel

Behaviour:
- Reset (rst low, asynchronous):
  - gradient=0, grad_valid=0, grad_sof=0.
  - col/row counters=0, pipeline valid bits=0, synced flag=0.
  - Line buffer RAM contents are not reset.
- Sync:
  - After reset, pixels are ignored until the first pix_valid&&sof; synced is then set.
  - While unsynced: no outputs, counters held at 0.
- Accepted pixel = pix_valid && (synced || sof).
- Counters on each accepted pixel:
  - If sof: this pixel is (row=0, col=0).
  - Otherwise col increments. At col=IMG_WIDTH-1, col wraps to 0 and row increments.
  - At the last pixel (row=IMG_HEIGHT-1, col=IMG_WIDTH-1), row wraps to 0.
- Mid-frame sof: counters restart at (0,0) with that pixel; no other side effects. Stale line buffer data is masked by the border rule below.
- Window:
  - Window rows are: line buffer 1 (row-2), line buffer 0 (row-1), and the incoming pixel (row).
  - Line buffers are read-before-write at address col. On accept, buffer0[col]←pix_in and buffer1[col]←old buffer0[col].
  - Three 3-deep column shift registers advance only on accepted pixels.
- Labelling: for an input at (r,c), the window is p[i][j] for rows r-2..r and cols c-2..c. The output is labelled for center (r-1,c-1), i.e. a one-pixel up-left spatial offset.
- Arithmetic:
  - Gx = (p02+2p12+p22) − (p00+2p10+p20), signed 11 bits, range ±1020.
  - Gy = (p20+2p21+p22) − (p00+2p01+p02), same range.
  - gradient = |Gx|+|Gy|, max 2040. Bits [15:11] are always 0.
- Border rule: if r<2 or c<2 at the input pixel, gradient=0. grad_valid is still asserted.
- Latency:
  - grad_valid rises exactly 3 clk edges after the accepting edge.
  - The pipeline is free-running; a gap in pix_valid creates the same gap at the output.
  - Back-to-back input produces back-to-back output. Output order equals input order.
- grad_sof is carried through the pipeline with the sof pixel. It is only ever high when grad_valid is high.
- Throughput: 1 pixel/clk sustained.

Test Plan:
1. Reset: hold rst low, drive pix_valid=1 -> gradient=0, grad_valid=0, grad_sof=0. Release rst and drive 5 pixels with sof=0 -> no grad_valid.
2. Flat frame, IMG_WIDTH=8, IMG_HEIGHT=6, all pixels 100, sof on the first pixel, continuous -> 48 grad_valid pulses, all gradient=0. grad_sof on the first pulse, 3 cycles after the sof edge.
3. Vertical step, same size: cols 0-3=0, cols 4-7=200 -> for input rows≥2, gradient=800 at input cols 4 and 5 and 0 elsewhere; rows 0-1 all 0.
4. Horizontal step: rows 0-2=0, rows 3-5=255 -> gradient=1020 at input rows 3 and 4 for cols≥2; 0 elsewhere.
5. Gapped input: repeat test 3 with pix_valid toggling 1/0 -> identical gradient sequence. Each grad_valid occurs exactly 3 cycles after its accepting edge, with output gaps matching input gaps.
6. Mid-frame restart: send 10 pixels, then sof with a new constant frame of 50 -> grad_sof on the 11th output; the first 16 outputs (rows 0-1) after it are 0; all remaining outputs are 0. Asynchronous reset asserted mid-frame -> outputs drop to 0 immediately and resync waits for the next sof.

Source files
------------

// File: rtl/sobel_gradient.sv
// sobel_gradient: streaming 3x3 Sobel |Gx|+|Gy| over a raster 8-bit pixel stream
module sobel_gradient #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int COL_W      = 9,
  parameter int ROW_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  input  logic        sof,
  output logic [15:0] gradient,
  output logic        grad_valid,
  output logic        grad_sof
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  logic             synced;
  logic [COL_W-1:0] col, cur_col;
  logic [ROW_W-1:0] row, cur_row;
  logic             accept;
  logic [7:0]       lb0 [IMG_WIDTH];
  logic [7:0]       lb1 [IMG_WIDTH];
  logic [7:0]       tap0, tap1;
  logic [7:0]       win [3][3];
  logic [10:0]      xp, xn, yp, yn;
  logic             v1, s1, b1, v2, s2, b2, v3, s3, b3;
  logic [10:0]      gx, gy;
  logic [9:0]       ax, ay;
  assign accept  = pix_valid && (synced || sof);
  assign cur_col = sof ? '0 : col;
  assign cur_row = sof ? '0 : row;
  assign tap0    = lb0[cur_col];
  assign tap1    = lb1[cur_col];
  assign xp = 11'(win[0][2]) + {2'b0, win[1][2], 1'b0} + 11'(win[2][2]);
  assign xn = 11'(win[0][0]) + {2'b0, win[1][0], 1'b0} + 11'(win[2][0]);
  assign yp = 11'(win[2][0]) + {2'b0, win[2][1], 1'b0} + 11'(win[2][2]);
  assign yn = 11'(win[0][0]) + {2'b0, win[0][1], 1'b0} + 11'(win[0][2]);
  // line buffers (read-before-write) and the 3x3 window shift on every accepted pixel
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[cur_col] <= pix_in;
      lb1[cur_col] <= tap0;
      win[0] <= '{win[0][1], win[0][2], tap1};
      win[1] <= '{win[1][1], win[1][2], tap0};
      win[2] <= '{win[2][1], win[2][2], pix_in};
    end
  end
  // frame sync and raster position of the next pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      synced <= 1'b0;
      col    <= '0;
      row    <= '0;
    end else if (accept) begin
      synced <= 1'b1;
      col    <= (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
      row    <= (cur_col != COL_LAST) ? cur_row : (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
    end
  end
  // three-stage arithmetic pipeline: border/sof tagging, signed gradients, magnitudes, sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {v1, s1, b1, v2, s2, b2, v3, s3, b3} <= '0;
      gx         <= '0;
      gy         <= '0;
      ax         <= '0;
      ay         <= '0;
      gradient   <= '0;
      grad_valid <= 1'b0;
      grad_sof   <= 1'b0;
    end else begin
      v1         <= accept;
      s1         <= accept && sof;
      b1         <= (cur_row < ROW_W'(2)) || (cur_col < COL_W'(2));
      v2         <= v1;
      s2         <= s1;
      b2         <= b1;
      gx         <= xp - xn;
      gy         <= yp - yn;
      v3         <= v2;
      s3         <= s2;
      b3         <= b2;
      ax         <= gx[10] ? 10'(-gx) : gx[9:0];
      ay         <= gy[10] ? 10'(-gy) : gy[9:0];
      grad_valid <= v3;
      grad_sof   <= s3;
      gradient   <= (v3 && !b3) ? {5'b0, 11'(ax) + 11'(ay)} : '0;
    end
  end
endmodule

// File: tb/tb_sobel_gradient.sv
// tb_sobel_gradient: directed and random frames checked against a convolution model
module tb_sobel_gradient;
  localparam int W = 8;
  localparam int H = 6;
  typedef struct {
    int e;
    int g;
    bit s;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        sof = 1'b0;
  logic [15:0] gradient;
  logic        grad_valid;
  logic        grad_sof;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   mr = 0;
  int   mc = 0;
  int   sum_g = 0;
  bit   synced_m = 1'b0;
  int   img [H][W];
  exp_t q [$];

  sobel_gradient #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(3), .ROW_W(3)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .gradient(gradient), .grad_valid(grad_valid), .grad_sof(grad_sof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return x < 0 ? -x : x;
  endfunction

  function automatic int model_grad(input int r, input int c);
    int gx, gy;
    if (r < 2 || c < 2) return 0;
    gx = 0;
    gy = 0;
    for (int k = 0; k < 3; k++) begin
      gx += (k == 1 ? 2 : 1) * (img[r-2+k][c] - img[r-2+k][c-2]);
      gy += (k == 1 ? 2 : 1) * (img[r][c-2+k] - img[r-2][c-2+k]);
    end
    return iabs(gx) + iabs(gy);
  endfunction

  function automatic logic [7:0] pat(input int mode, input int r, input int c);
    case (mode)
      0: return 8'd100;
      1: return c >= 4 ? 8'd200 : 8'd0;
      2: return r >= 3 ? 8'd255 : 8'd0;
      3: return 8'($urandom);
      default: return 8'd50;
    endcase
  endfunction

  task automatic step(input logic v, input logic s, input logic [7:0] p);
    exp_t x;
    pix_valid = v;
    sof = s;
    pix_in = p;
    @(posedge clk);
    cyc++;
    if (rst && v && (synced_m || s)) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      synced_m = 1'b1;
      img[mr][mc] = int'(p);
      x.e = cyc;
      x.g = model_grad(mr, mc);
      x.s = s;
      q.push_back(x);
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else mc++;
    end
    #1;
    if (q.size() > 0 && q[0].e == cyc - 3) begin
      chk("grad_valid", 16'(grad_valid), 16'd1);
      chk("gradient", gradient, 16'(q[0].g));
      chk("grad_sof", 16'(grad_sof), 16'(q[0].s));
      sum_g += int'(gradient);
      void'(q.pop_front());
    end else begin
      chk("grad_valid_idle", 16'(grad_valid), 16'd0);
      chk("grad_sof_idle", 16'(grad_sof), 16'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_pixels(input int mode, input int gap, input int n);
    for (int k = 0; k < n; k++) begin
      if (gap == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      step(1'b1, k == 0, pat(mode, k / W, k % W));
      if (gap == 1) idle(1);
    end
  endtask

  task automatic send_frame(input int mode, input int gap);
    send_pixels(mode, gap, W * H);
    idle(4);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i[0], 8'($urandom));
      chk("reset_gradient", gradient, 16'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
    sum_g = 0;
    send_frame(0, 0);
    chk("flat_sum", 16'(sum_g), 16'd0);
    sum_g = 0;
    send_frame(1, 0);
    chk("vstep_sum", 16'(sum_g), 16'd6400);
    sum_g = 0;
    send_frame(2, 0);
    chk("hstep_sum", 16'(sum_g), 16'd12240);
    sum_g = 0;
    send_frame(1, 1);
    chk("vstep_gapped_sum", 16'(sum_g), 16'd6400);
    send_pixels(3, 0, 10);
    sum_g = 0;
    send_frame(4, 0);
    chk("restart_sum", 16'(sum_g), 16'd0);
    send_frame(3, 2);
    send_frame(3, 0);
    send_pixels(3, 0, 20);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 16'(grad_valid), 16'd0);
    chk("async_rst_gradient", gradient, 16'd0);
    chk("async_rst_sof", 16'(grad_sof), 16'd0);
    q.delete();
    synced_m = 1'b0;
    step(1'b1, 1'b1, 8'd7);
    step(1'b1, 1'b0, 8'd9);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'($urandom));
    send_frame(3, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
